// File: rtl/mul_rs_scheduler_if.sv
// Issue, CDB snoop, multiplier and CDB-result signals shared between the
// multiplier reservation-station scheduler and its environment.
interface mul_rs_scheduler_if #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 8
);
  logic              iss_valid;
  logic              iss_ready;
  logic [TAG_W-1:0]  iss_dst_tag;
  logic              iss_v1;
  logic [TAG_W-1:0]  iss_q1;
  logic [DATA_W-1:0] iss_d1;
  logic              iss_v2;
  logic [TAG_W-1:0]  iss_q2;
  logic [DATA_W-1:0] iss_d2;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              mul_start;
  logic [DATA_W-1:0] mul_op_a;
  logic [DATA_W-1:0] mul_op_b;
  logic [TAG_W-1:0]  mul_tag;
  logic              mul_done;
  logic [DATA_W-1:0] mul_result;

  logic              cdb_req;
  logic              cdb_gnt;
  logic [TAG_W-1:0]  cdb_out_tag;
  logic [DATA_W-1:0] cdb_out_data;

  modport master (
    output iss_valid, iss_dst_tag, iss_v1, iss_q1, iss_d1, iss_v2, iss_q2, iss_d2,
    output cdb_valid, cdb_tag, cdb_data, mul_done, mul_result, cdb_gnt,
    input  iss_ready, mul_start, mul_op_a, mul_op_b, mul_tag,
    input  cdb_req, cdb_out_tag, cdb_out_data
  );

  modport slave (
    input  iss_valid, iss_dst_tag, iss_v1, iss_q1, iss_d1, iss_v2, iss_q2, iss_d2,
    input  cdb_valid, cdb_tag, cdb_data, mul_done, mul_result, cdb_gnt,
    output iss_ready, mul_start, mul_op_a, mul_op_b, mul_tag,
    output cdb_req, cdb_out_tag, cdb_out_data
  );
endinterface

// File: rtl/mul_rs_scheduler.sv
// Multiplier reservation station: holds issued ops until both operands are
// known (via CDB snoop), dispatches one at a time and drives the result to the CDB.
module mul_rs_scheduler #(
  parameter int RS_DEPTH = 3,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  mul_rs_scheduler_if.slave   bus,
  output logic [2:0]          rs_count
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state_reg, state_next;
  logic [RS_DEPTH-1:0] busy_reg, v1_reg, v2_reg, rdy;
  logic [TAG_W-1:0]  dst_reg [RS_DEPTH];
  logic [TAG_W-1:0]  q1_reg  [RS_DEPTH];
  logic [TAG_W-1:0]  q2_reg  [RS_DEPTH];
  logic [DATA_W-1:0] d1_reg  [RS_DEPTH];
  logic [DATA_W-1:0] d2_reg  [RS_DEPTH];

  logic              start_reg, start_next;
  logic [DATA_W-1:0] op_a_reg, op_a_next, op_b_reg, op_b_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic              req_reg, req_next;
  logic [TAG_W-1:0]  out_tag_reg, out_tag_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;

  logic              free_found, rdy_found, iss_fire, disp_fire;
  logic [IDX_W-1:0]  free_idx, rdy_idx;
  logic              byp1, byp2;

  genvar gi;
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_rdy
      assign rdy[gi] = busy_reg[gi] & v1_reg[gi] & v2_reg[gi];
    end
  endgenerate

  // Reverse scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    rs_count   = 3'd0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (rdy[i]) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
      rs_count = rs_count + 3'(busy_reg[i]);
    end
  end

  assign bus.iss_ready = free_found;
  assign iss_fire      = bus.iss_valid & free_found;
  assign disp_fire     = (state_reg == IDLE) & rdy_found;
  assign byp1 = bus.cdb_valid & (bus.iss_q1 == bus.cdb_tag);
  assign byp2 = bus.cdb_valid & (bus.iss_q2 == bus.cdb_tag);

  // The issue target is always a free slot and the dispatch source a busy one,
  // so a slot is never both written and freed in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
      v1_reg   <= '0;
      v2_reg   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        dst_reg[i] <= '0;
        q1_reg[i]  <= '0;
        q2_reg[i]  <= '0;
        d1_reg[i]  <= '0;
        d2_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (disp_fire && rdy_idx == IDX_W'(i)) begin
          busy_reg[i] <= 1'b0;
        end else if (busy_reg[i] && bus.cdb_valid) begin
          if (!v1_reg[i] && q1_reg[i] == bus.cdb_tag) begin
            v1_reg[i] <= 1'b1;
            d1_reg[i] <= bus.cdb_data;
          end
          if (!v2_reg[i] && q2_reg[i] == bus.cdb_tag) begin
            v2_reg[i] <= 1'b1;
            d2_reg[i] <= bus.cdb_data;
          end
        end
        if (iss_fire && free_idx == IDX_W'(i)) begin
          busy_reg[i] <= 1'b1;
          dst_reg[i]  <= bus.iss_dst_tag;
          q1_reg[i]   <= bus.iss_q1;
          q2_reg[i]   <= bus.iss_q2;
          v1_reg[i]   <= bus.iss_v1 | byp1;
          v2_reg[i]   <= bus.iss_v2 | byp2;
          d1_reg[i]   <= bus.iss_v1 ? bus.iss_d1 : (byp1 ? bus.cdb_data : bus.iss_d1);
          d2_reg[i]   <= bus.iss_v2 ? bus.iss_d2 : (byp2 ? bus.cdb_data : bus.iss_d2);
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_next    = 1'b0;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    tag_next      = tag_reg;
    req_next      = req_reg;
    out_tag_next  = out_tag_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      IDLE: begin
        if (rdy_found) begin
          start_next = 1'b1;
          op_a_next  = d1_reg[rdy_idx];
          op_b_next  = d2_reg[rdy_idx];
          tag_next   = dst_reg[rdy_idx];
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (bus.mul_done) begin
          out_data_next = bus.mul_result;
          out_tag_next  = tag_reg;
          req_next      = 1'b1;
          state_next    = WB;
        end
      end
      WB: begin
        // Returning to IDLE also restores the zero idle values on all outputs.
        if (bus.cdb_gnt) begin
          req_next      = 1'b0;
          out_tag_next  = '0;
          out_data_next = '0;
          op_a_next     = '0;
          op_b_next     = '0;
          tag_next      = '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      start_reg    <= 1'b0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      tag_reg      <= '0;
      req_reg      <= 1'b0;
      out_tag_reg  <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      start_reg    <= start_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      tag_reg      <= tag_next;
      req_reg      <= req_next;
      out_tag_reg  <= out_tag_next;
      out_data_reg <= out_data_next;
    end
  end

  assign bus.mul_start    = start_reg;
  assign bus.mul_op_a     = op_a_reg;
  assign bus.mul_op_b     = op_b_reg;
  assign bus.mul_tag      = tag_reg;
  assign bus.cdb_req      = req_reg;
  assign bus.cdb_out_tag  = out_tag_reg;
  assign bus.cdb_out_data = out_data_reg;
endmodule

// File: tb/tb_mul_rs_scheduler.sv
// Directed bench for mul_rs_scheduler: inputs change and outputs are checked
// on the falling edge, one rising edge per step.
module tb_mul_rs_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rs_count;
  int         n_cmp = 0;
  int         n_err = 0;

  mul_rs_scheduler_if #(.TAG_W(3), .DATA_W(8)) bus ();

  mul_rs_scheduler #(.RS_DEPTH(3), .TAG_W(3), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rs_count (rs_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] dst, input logic v1, input logic [2:0] q1,
                       input logic [7:0] d1, input logic v2, input logic [2:0] q2,
                       input logic [7:0] d2);
    bus.iss_valid   = 1'b1;
    bus.iss_dst_tag = dst;
    bus.iss_v1 = v1; bus.iss_q1 = q1; bus.iss_d1 = d1;
    bus.iss_v2 = v2; bus.iss_q2 = q2; bus.iss_d2 = d2;
  endtask

  initial begin
    rst = 1'b1;
    bus.iss_valid = 0; bus.iss_dst_tag = 0;
    bus.iss_v1 = 0; bus.iss_q1 = 0; bus.iss_d1 = 0;
    bus.iss_v2 = 0; bus.iss_q2 = 0; bus.iss_d2 = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    bus.mul_done = 0; bus.mul_result = 0; bus.cdb_gnt = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", bus.iss_ready, 1);
    chk("rst_count", rs_count, 0);
    chk("rst_start", bus.mul_start, 0);
    chk("rst_req", bus.cdb_req, 0);
    chk("rst_opa", bus.mul_op_a, 0);
    chk("rst_outdata", bus.cdb_out_data, 0);

    // Basic issue -> dispatch -> execute -> writeback
    issue(3'd1, 1, 3'd0, 8'd3, 1, 3'd0, 8'd5);
    step(); bus.iss_valid = 0;
    chk("t1_count1", rs_count, 1);
    chk("t1_nostart", bus.mul_start, 0);
    step();
    chk("t1_start", bus.mul_start, 1);
    chk("t1_opa", bus.mul_op_a, 3);
    chk("t1_opb", bus.mul_op_b, 5);
    chk("t1_tag", bus.mul_tag, 1);
    chk("t1_count0", rs_count, 0);
    step();
    chk("t1_pulse", bus.mul_start, 0);
    chk("t1_opa_hold", bus.mul_op_a, 3);
    bus.mul_done = 1; bus.mul_result = 8'd15;
    step(); bus.mul_done = 0;
    chk("t1_req", bus.cdb_req, 1);
    chk("t1_otag", bus.cdb_out_tag, 1);
    chk("t1_odata", bus.cdb_out_data, 15);
    step();
    chk("t1_req_hold", bus.cdb_req, 1);
    bus.cdb_gnt = 1;
    step(); bus.cdb_gnt = 0;
    chk("t1_req_off", bus.cdb_req, 0);
    chk("t1_odata_idle", bus.cdb_out_data, 0);
    chk("t1_opa_idle", bus.mul_op_a, 0);

    // Operand 1 waits on tag 4, captured by snoop
    issue(3'd2, 0, 3'd4, 8'd0, 1, 3'd0, 8'd6);
    step(); bus.iss_valid = 0;
    chk("t2_count", rs_count, 1);
    step(); step();
    chk("t2_wait", bus.mul_start, 0);
    bus.cdb_valid = 1; bus.cdb_tag = 3'd4; bus.cdb_data = 8'd7;
    step(); bus.cdb_valid = 0;
    chk("t2_not_yet", bus.mul_start, 0);
    step();
    chk("t2_start", bus.mul_start, 1);
    chk("t2_opa", bus.mul_op_a, 7);
    chk("t2_opb", bus.mul_op_b, 6);
    chk("t2_tag", bus.mul_tag, 2);
    bus.mul_done = 1; bus.mul_result = 8'd42;
    step(); bus.mul_done = 0;
    chk("t2_req", bus.cdb_req, 1);

    // Grant withheld for 4 cycles while a ready op waits in the station
    issue(3'd3, 1, 3'd0, 8'd2, 1, 3'd0, 8'd2);
    for (int k = 0; k < 4; k++) begin
      step(); bus.iss_valid = 0;
      chk("wb_req", bus.cdb_req, 1);
      chk("wb_odata", bus.cdb_out_data, 42);
      chk("wb_otag", bus.cdb_out_tag, 2);
      chk("wb_nostart", bus.mul_start, 0);
      chk("wb_opa", bus.mul_op_a, 7);
    end
    chk("wb_count", rs_count, 1);
    bus.cdb_gnt = 1;
    step(); bus.cdb_gnt = 0;
    chk("wb_req_off", bus.cdb_req, 0);
    chk("wb_gnt_nostart", bus.mul_start, 0);
    step();
    chk("wb_next_start", bus.mul_start, 1);
    chk("wb_next_opa", bus.mul_op_a, 2);
    chk("wb_next_tag", bus.mul_tag, 3);
    chk("wb_next_count", rs_count, 0);
    bus.mul_done = 1; bus.mul_result = 8'd4;
    step(); bus.mul_done = 0;
    bus.cdb_gnt = 1;
    step(); bus.cdb_gnt = 0;

    // Issue bypass: operand 2 arrives on the CDB in the issue cycle
    issue(3'd6, 1, 3'd0, 8'd3, 0, 3'd5, 8'd0);
    bus.cdb_valid = 1; bus.cdb_tag = 3'd5; bus.cdb_data = 8'd9;
    step(); bus.iss_valid = 0; bus.cdb_valid = 0;
    chk("t3_count", rs_count, 1);
    step();
    chk("t3_start", bus.mul_start, 1);
    chk("t3_opa", bus.mul_op_a, 3);
    chk("t3_opb", bus.mul_op_b, 9);
    chk("t3_tag", bus.mul_tag, 6);
    bus.mul_done = 1; bus.mul_result = 8'd27;
    step(); bus.mul_done = 0;
    chk("t3_odata", bus.cdb_out_data, 27);
    bus.cdb_gnt = 1;
    step(); bus.cdb_gnt = 0;

    // Fill the station, then a 4th issue is dropped
    for (int k = 1; k <= 3; k++) begin
      issue(3'(k), 0, 3'd7, 8'd0, 1, 3'd0, 8'(k));
      step();
    end
    bus.iss_valid = 0;
    chk("t4_full_count", rs_count, 3);
    chk("t4_full_ready", bus.iss_ready, 0);
    issue(3'd4, 1, 3'd0, 8'd1, 1, 3'd0, 8'd1);
    step(); bus.iss_valid = 0;
    chk("t4_drop_count", rs_count, 3);
    chk("t4_drop_nostart", bus.mul_start, 0);
    bus.cdb_valid = 1; bus.cdb_tag = 3'd7; bus.cdb_data = 8'd4;
    step(); bus.cdb_valid = 0;
    step();
    chk("t4_start", bus.mul_start, 1);
    chk("t4_tag", bus.mul_tag, 1);
    chk("t4_opa", bus.mul_op_a, 4);
    chk("t4_count2", rs_count, 2);
    chk("t4_ready", bus.iss_ready, 1);
    bus.mul_done = 1; bus.mul_result = 8'd4;
    step(); bus.mul_done = 0;
    bus.cdb_gnt = 1;
    step(); bus.cdb_gnt = 0;
    step();
    chk("t4_start2", bus.mul_start, 1);
    chk("t4_tag2", bus.mul_tag, 2);
    chk("t4_count1", rs_count, 1);

    // Reset in EXEC, then a stale mul_done
    rst = 1'b1;
    step(); rst = 1'b0;
    bus.mul_done = 1; bus.mul_result = 8'h55;
    step(); bus.mul_done = 0;
    chk("t5_req", bus.cdb_req, 0);
    chk("t5_odata", bus.cdb_out_data, 0);
    chk("t5_otag", bus.cdb_out_tag, 0);
    chk("t5_start", bus.mul_start, 0);
    chk("t5_opa", bus.mul_op_a, 0);
    chk("t5_opb", bus.mul_op_b, 0);
    chk("t5_tag", bus.mul_tag, 0);
    chk("t5_count", rs_count, 0);
    chk("t5_ready", bus.iss_ready, 1);
    step();
    chk("t5_req_later", bus.cdb_req, 0);
    chk("t5_start_later", bus.mul_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_rs_scheduler.md
MUL_RS_SCHEDULER -- requirements
Module: mul_rs_scheduler

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 3: number of multiplier reservation-station entries, range 2..4.
REQ-002 SHALL have parameter TAG_W, default 3: tag width.
REQ-003 SHALL have parameter DATA_W, default 8: operand and result width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports iss_valid in 1 and iss_ready out 1: issue handshake, transfer when both are high at posedge.
REQ-007 SHALL have port iss_dst_tag, input, TAG_W: result tag of the issued op.
REQ-008 SHALL have ports iss_v1 in 1, iss_q1 in TAG_W and iss_d1 in DATA_W: operand-1 valid flag, producer tag when invalid, and value when valid.
REQ-009 SHALL have ports iss_v2 in 1, iss_q2 in TAG_W and iss_d2 in DATA_W: the same fields for operand 2.
REQ-010 SHALL have ports cdb_valid in 1, cdb_tag in TAG_W and cdb_data in DATA_W: common-data-bus snoop.
REQ-011 SHALL have ports mul_start out 1, mul_op_a out DATA_W, mul_op_b out DATA_W and mul_tag out TAG_W: multiplier launch interface.
REQ-012 SHALL have ports mul_done in 1 and mul_result in DATA_W: multiplier completion.
REQ-013 SHALL have ports cdb_req out 1 and cdb_gnt in 1: CDB arbitration request and grant.
REQ-014 SHALL have ports cdb_out_tag out TAG_W and cdb_out_data out DATA_W: result driven onto the CDB.
REQ-015 SHALL have port rs_count, output, 3: number of occupied entries.

Function
REQ-016 SHALL hold per entry: busy, dst_tag, and for each operand v/q/d fields.
REQ-017 SHALL set iss_ready = 1 when any entry is not busy; iss_ready SHALL be derived from registered state only.
REQ-018 SHALL write an accepted issue into the lowest-index free entry.
REQ-019 SHALL, on a cdb_valid snoop, make every busy entry operand with v=0 and q==cdb_tag set v=1 and d=cdb_data at that posedge.
REQ-020 SHALL store the operand as valid with cdb_data when it is issued with v=0 in the same cycle that cdb_valid and cdb_tag==q (issue bypass).
REQ-021 SHALL treat an entry as ready when it is busy and both v flags are 1; a snoop-captured entry becomes ready the next cycle.
REQ-022 SHALL run an execution FSM with states IDLE, EXEC and WB.
REQ-023 IDLE: when any entry is ready, SHALL dispatch the lowest-index ready entry: pulse mul_start for 1 cycle, register mul_op_a=d1, mul_op_b=d2 and mul_tag=dst_tag, free the entry, and go to EXEC.
REQ-024 SHALL hold mul_op_a, mul_op_b and mul_tag stable through EXEC and WB.
REQ-025 EXEC: on mul_done=1, SHALL latch mul_result into cdb_out_data, set cdb_out_tag=mul_tag, assert cdb_req and go to WB.
REQ-026 SHALL ignore mul_done in IDLE and WB.
REQ-027 WB: SHALL hold cdb_req=1 and the cdb_out fields until cdb_gnt=1 at a posedge, then deassert cdb_req and go to IDLE; the next dispatch is 1 cycle later at the earliest.
REQ-028 SHALL ignore cdb_gnt while cdb_req=0.
REQ-029 Issue, snoop and dispatch in one cycle: a slot freed by dispatch SHALL become issuable only the following cycle, and an entry SHALL never be both dispatched and written in the same cycle.
REQ-030 Full (rs_count==RS_DEPTH): SHALL drive iss_ready=0; issue attempts SHALL have no effect.
REQ-031 SHALL update rs_count the same cycle as an issue (+1) or dispatch (-1), and SHALL leave it unchanged when both occur.
REQ-032 SHALL never drive outputs to Z or X; idle values SHALL be 0.

Reset
REQ-033 On rst=1 at posedge, SHALL clear all entries to not busy, set FSM=IDLE and rs_count=0, and drive mul_start=0, cdb_req=0 and all data/tag outputs=0.
REQ-034 SHALL let reset take priority over every event, including mid-EXEC and mid-WB; the in-flight result is discarded and any later mul_done is ignored.

Verification
REQ-035 Issue tag=1, d1=3, d2=5, both valid -> mul_start pulse next cycle with op_a=3, op_b=5, mul_tag=1; mul_done with 15 -> cdb_req=1, out_tag=1, out_data=15 until gnt.
REQ-036 Issue tag=2 waiting on q1=4, then cdb_valid with tag=4, data=7 -> entry ready 1 cycle later, dispatch with op_a=7.
REQ-037 Issue with q2=5 in the same cycle as a CDB broadcast of tag=5, data=9 -> stored valid, dispatch with op_b=9.
REQ-038 Issue 3 ops with no CDB grant -> rs_count=3, iss_ready=0; a 4th issue is dropped; after dispatch, iss_ready=1 the next cycle.
REQ-039 Hold cdb_gnt=0 for 4 cycles in WB -> cdb_req and data stable, no dispatch; gnt=1 -> IDLE, next dispatch 1 cycle later.
REQ-040 Assert rst during EXEC, then pulse mul_done -> all outputs 0, rs_count=0, no cdb_req.
